// File: rtl/ie_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the IE stage: 32-step shift-add multiply
// or restoring divide on operand magnitudes, sign fix-up, and ownership of HI/LO.
module ie_muldiv_sequencer #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_rs,
    input  logic [NB_DATA-1:0] i_rt,
    input  logic               i_mf_req,
    input  logic               i_flush,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_stall,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);

    localparam int NB_CNT = $clog2(NB_DATA);
    localparam int NB_ACC = 2 * NB_DATA;

    // Handshake: i_start is accepted only on an edge where o_busy=0 and i_flush=0;
    // o_done pulses for one cycle while o_hi/o_lo already hold the new result.
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIXUP} state_t;

    state_t              state, state_nxt;
    logic [NB_CNT-1:0]   cnt, cnt_nxt;
    logic [NB_OP-1:0]    op_q, op_nxt;
    logic                sign_a, sign_a_nxt, sign_b, sign_b_nxt;
    logic                dz_q, dz_nxt;
    logic [NB_DATA-1:0]  mcand, mcand_nxt;
    logic [NB_ACC-1:0]   acc, acc_nxt;
    logic [NB_DATA-1:0]  hi_nxt, lo_nxt;
    logic                done_nxt;

    logic                in_signed;
    logic [NB_DATA-1:0]  mag_rs, mag_rt;
    logic [NB_DATA:0]    add_sum, sub_diff;
    logic [NB_ACC-1:0]   prod_neg;
    logic [NB_DATA-1:0]  quo_neg, rem_neg;

    assign in_signed = ~i_op[0];
    assign mag_rs    = (in_signed & i_rs[NB_DATA-1]) ? -i_rs : i_rs;
    assign mag_rt    = (in_signed & i_rt[NB_DATA-1]) ? -i_rt : i_rt;

    // Partial remainder is 33 bits wide after the shift when the divisor exceeds 2^31.
    assign add_sum  = {1'b0, acc[NB_ACC-1:NB_DATA]} + (acc[0] ? {1'b0, mcand} : {(NB_DATA+1){1'b0}});
    assign sub_diff = acc[NB_ACC-1:NB_DATA-1] - {1'b0, mcand};
    assign prod_neg = -acc;
    assign quo_neg  = -acc[NB_DATA-1:0];
    assign rem_neg  = -acc[NB_ACC-1:NB_DATA];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        op_nxt     = op_q;
        sign_a_nxt = sign_a;
        sign_b_nxt = sign_b;
        dz_nxt     = dz_q;
        mcand_nxt  = mcand;
        acc_nxt    = acc;
        hi_nxt     = o_hi;
        lo_nxt     = o_lo;
        done_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!i_flush && i_start) begin
                    op_nxt     = i_op;
                    sign_a_nxt = in_signed & i_rs[NB_DATA-1];
                    sign_b_nxt = in_signed & i_rt[NB_DATA-1];
                    cnt_nxt    = '0;
                    dz_nxt     = 1'b0;
                    state_nxt  = ST_RUN;
                    if (i_op[1]) begin
                        acc_nxt   = {{NB_DATA{1'b0}}, mag_rs};
                        mcand_nxt = mag_rt;
                        if (i_rt == '0) begin
                            // Raw dividend kept for HI; the iterations are skipped.
                            dz_nxt    = 1'b1;
                            acc_nxt   = {{NB_DATA{1'b0}}, i_rs};
                            state_nxt = ST_FIXUP;
                        end
                    end else begin
                        acc_nxt   = {{NB_DATA{1'b0}}, mag_rt};
                        mcand_nxt = mag_rs;
                    end
                end
            end
            ST_RUN: begin
                if (i_flush) begin
                    state_nxt = ST_IDLE;
                end else begin
                    if (op_q[1]) begin
                        if (sub_diff[NB_DATA])
                            acc_nxt = {acc[NB_ACC-2:0], 1'b0};
                        else
                            acc_nxt = {sub_diff[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b1};
                    end else begin
                        acc_nxt = {add_sum, acc[NB_DATA-1:1]};
                    end
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == NB_CNT'(NB_DATA - 1))
                        state_nxt = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                state_nxt = ST_IDLE;
                if (!i_flush) begin
                    done_nxt = 1'b1;
                    if (dz_q) begin
                        lo_nxt = '1;
                        hi_nxt = acc[NB_DATA-1:0];
                    end else if (op_q[1]) begin
                        lo_nxt = (sign_a ^ sign_b) ? quo_neg : acc[NB_DATA-1:0];
                        hi_nxt = sign_a ? rem_neg : acc[NB_ACC-1:NB_DATA];
                    end else begin
                        {hi_nxt, lo_nxt} = (sign_a ^ sign_b) ? prod_neg : acc;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dz_q   <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            o_hi   <= '0;
            o_lo   <= '0;
            o_done <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            op_q   <= op_nxt;
            sign_a <= sign_a_nxt;
            sign_b <= sign_b_nxt;
            dz_q   <= dz_nxt;
            mcand  <= mcand_nxt;
            acc    <= acc_nxt;
            o_hi   <= hi_nxt;
            o_lo   <= lo_nxt;
            o_done <= done_nxt;
        end
    end

    assign o_busy  = (state != ST_IDLE);
    assign o_stall = o_busy & (i_start | i_mf_req);

endmodule

// File: tb/tb_ie_muldiv_sequencer.sv
// Self-checking bench for ie_muldiv_sequencer: directed vector table, multi-cycle
// corner sequences (flush, reset, stall, back-to-back) and random ops vs a model.
module tb_ie_muldiv_sequencer;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = '0;
    logic [31:0] i_rs = '0;
    logic [31:0] i_rt = '0;
    logic        i_mf_req = 1'b0;
    logic        i_flush = 1'b0;
    logic        o_busy, o_done, o_stall;
    logic [31:0] o_hi, o_lo;

    int checks = 0;
    int errors = 0;
    int busy_bad = 0;

    ie_muldiv_sequencer #(.NB_DATA(32), .NB_OP(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
        .i_rs(i_rs), .i_rt(i_rt), .i_mf_req(i_mf_req), .i_flush(i_flush),
        .o_busy(o_busy), .o_done(o_done), .o_stall(o_stall), .o_hi(o_hi), .o_lo(o_lo)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: widen to 64 bits and let the language do signed/unsigned math.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        ua = {32'b0, rs};
        ub = {32'b0, rt};
        case (op)
            OP_MULT:  return sa * sb;
            OP_MULTU: return ua * ub;
            default: begin
                if (rt == 0) return {rs, 32'hFFFF_FFFF};
                if (op == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        i_start = 1'b1;
        i_op = op;
        i_rs = rs;
        i_rt = rt;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    // Counts edges after the start edge until o_done; checks busy/stall each cycle before.
    task automatic wait_done(output int n);
        bit got;
        n = 0;
        got = 0;
        while (!got && n < 100) begin
            @(posedge i_clk);
            n++;
            #1;
            if (o_done) got = 1;
            else begin
                if (o_busy !== 1'b1) busy_bad++;
                if (o_stall !== (i_start | i_mf_req)) busy_bad++;
            end
        end
        if (!got) chk("done_timeout", 64'(got), 64'd1);
    endtask

    task automatic run_check(input string name, input logic [1:0] op, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [63:0] exp, input int lat);
        int n;
        busy_bad = 0;
        @(negedge i_clk);
        issue(op, rs, rt);
        wait_done(n);
        chk({name, "_latency"}, 64'(n), 64'(lat));
        chk({name, "_hilo"}, {o_hi, o_lo}, exp);
        chk({name, "_busy_window"}, 64'(busy_bad), 64'd0);
        chk({name, "_busy_at_done"}, 64'(o_busy), 64'd0);
        @(posedge i_clk);
        #1;
        chk({name, "_done_pulse"}, 64'(o_done), 64'd0);
    endtask

    task automatic no_done_for(input string name, input int cycles);
        int seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge i_clk);
            #1;
            if (o_done) seen++;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    initial begin
        vec_t vecs[10];
        int   n, n2, sbad;
        logic [1:0]  rop;
        logic [31:0] rrs, rrt;

        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
        vecs[5] = '{OP_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
        vecs[6] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         33};
        vecs[7] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
        vecs[8] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1,         33};
        vecs[9] = '{OP_DIVU,  32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1};

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_done", 64'(o_done), 64'd0);
        chk("reset_stall", 64'(o_stall), 64'd0);
        chk("reset_hilo", {o_hi, o_lo}, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                      {vecs[i].hi, vecs[i].lo}, vecs[i].lat);

        // Flush at RUN iteration 10 after a MULTU preload
        run_check("preload", OP_MULTU, 32'd2, 32'd3, 64'd6, 33);
        @(negedge i_clk);
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (10) @(posedge i_clk);
        #1;
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        chk("flush_idle", 64'(o_busy), 64'd0);
        no_done_for("flush_no_done", 40);
        chk("flush_hilo_kept", {o_hi, o_lo}, 64'd6);

        // Flush in IDLE drops a simultaneous start
        @(negedge i_clk);
        i_start = 1'b1; i_flush = 1'b1; i_op = OP_MULTU; i_rs = 32'd5; i_rt = 32'd5;
        @(posedge i_clk);
        #1;
        i_start = 1'b0; i_flush = 1'b0;
        chk("idle_flush_drops_start", 64'(o_busy), 64'd0);
        no_done_for("idle_flush_no_done", 40);

        // Busy-time start is ignored and stalls; mf_req stalls until the done cycle
        busy_bad = 0;
        sbad = 0;
        @(negedge i_clk);
        issue(OP_DIVU, 32'd100, 32'd7);
        for (int k = 0; k < 8; k++) begin
            i_start = 1'b1; i_op = OP_MULT; i_rs = 32'd9; i_rt = 32'd9;
            @(posedge i_clk);
            #1;
            if (o_stall !== 1'b1) sbad++;
        end
        i_start = 1'b0;
        i_mf_req = 1'b1;
        wait_done(n);
        chk("busy_start_stall", 64'(sbad), 64'd0);
        chk("mf_stall_window", 64'(busy_bad), 64'd0);
        chk("stall_at_done", 64'(o_stall), 64'd0);
        chk("ignored_start_latency", 64'(n), 64'd25);
        chk("ignored_start_hilo", {o_hi, o_lo}, {32'd2, 32'd14});
        i_mf_req = 1'b0;

        // Back-to-back: start in the done cycle
        @(negedge i_clk);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        chk("b2b_first_hilo", {o_hi, o_lo}, {32'hFFFF_FFFE, 32'h1});
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(n2);
        chk("b2b_spacing", 64'(n2 + 1), 64'd34);
        chk("b2b_second_hilo", {o_hi, o_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // Asynchronous reset mid-RUN
        @(negedge i_clk);
        issue(OP_DIVU, 32'd100, 32'd7);
        i_mf_req = 1'b1;
        repeat (5) @(posedge i_clk);
        #3;
        chk("pre_reset_stall", 64'(o_stall), 64'd1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(o_busy), 64'd0);
        chk("midrst_stall", 64'(o_stall), 64'd0);
        chk("midrst_done", 64'(o_done), 64'd0);
        chk("midrst_hilo", {o_hi, o_lo}, 64'd0);
        i_mf_req = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        no_done_for("midrst_no_done", 40);

        // Random operations against the model
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            rrs = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            rrt = ($urandom_range(0, 7) == 0) ? 32'd0 :
                  ((i % 4 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
            if (i == 5) begin rop = OP_DIV; rrs = 32'h8000_0000; rrt = 32'hFFFF_FFFF; end
            run_check($sformatf("rand%0d", i), rop, rrs, rrt, model(rop, rrs, rrt),
                      (rop[1] && rrt == 0) ? 1 : 33);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ie_muldiv_sequencer.md
# ie_muldiv_sequencer

Iterative multiply/divide sequencer for the execute (IE) stage. It accepts MULT, MULTU, DIV and DIVU from the decoded instruction and runs a 32-step shift-add multiply or a restoring divide. It owns the HI/LO registers and raises a stall to the pipeline controller while a result is pending and an instruction needs the unit or its results. Operands arrive already resolved from the IE operand multiplexers, i.e. after forwarding.

## Interface

- NB_DATA, 32, operand and HI/LO width
- NB_OP, 2, operation code width
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  request a new operation; sampled only in IDLE
- i_op  in  NB_OP  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- i_rs  in  NB_DATA  operand A: multiplicand or dividend
- i_rt  in  NB_DATA  operand B: multiplier or divisor
- i_mf_req  in  1  the IE instruction is MFHI/MFLO
- i_flush  in  1  abort the in-flight operation
- o_busy  out  1  operation in progress
- o_done  out  1  one-cycle pulse; HI/LO are updated in this cycle
- o_stall  out  1  stall request to the pipeline
- o_hi  out  NB_DATA  HI register: product high word or remainder
- o_lo  out  NB_DATA  LO register: product low word or quotient

## Operation

- States:
  - IDLE
  - RUN: 32 iterations, 5-bit counter
  - FIXUP: sign correction and HI/LO write
- **IDLE.** i_start=1 latches the operands and the op, then goes to RUN with counter=0.
  - Signed ops store operand magnitudes plus the sign of each operand.
  - DIV/DIVU with i_rt==0 skips RUN and goes to FIXUP.
- **RUN.** One iteration per cycle.
  - Multiply: 64-bit accumulator, conditional add of the multiplicand, then shift right 1.
  - Divide: 64-bit remainder:quotient register, shift left 1, trial subtract of the divisor, restore on borrow.
  - All arithmetic is unsigned on magnitudes, with a 33-bit adder/subtractor.
  - When counter==31, the next state is FIXUP.
- **FIXUP.**
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Divide by zero: LO=0xFFFFFFFF, HI=i_rs as latched (unsigned, unmodified).
  - Writes HI/LO, sets o_done, and returns to IDLE.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This is a defined result, not an error.
- Interaction with the pipeline:
  - i_start while busy is ignored, and o_stall is raised.
  - o_stall = o_busy & (i_start | i_mf_req). It is combinational.
- i_flush:
  - In RUN or FIXUP, the next edge goes to IDLE.
  - HI/LO are unchanged and no o_done is produced.
  - In IDLE, i_flush has priority over i_start, so the start is dropped.
- o_hi/o_lo change only in the FIXUP→IDLE edge and at reset.

## Timing

- Reset (asynchronous, i_rst_n=0):
  - State becomes IDLE and the counter becomes 0.
  - o_busy=0, o_done=0, o_stall=0, o_hi=0, o_lo=0.
  - Applies immediately, including mid-operation.
  - The first edge after release behaves as IDLE.
- Normal latency: take E0 as the edge that samples i_start.
  - o_busy=1 from after E0.
  - RUN spans edges E1..E32.
  - FIXUP executes at E33.
  - o_done=1 and HI/LO are valid in the cycle after E33.
  - o_busy=0 in that same cycle.
- Divide-by-zero latency: FIXUP at E1; o_done in the cycle after E1.
- Back-to-back: i_start during the o_done cycle is accepted, because the state is IDLE. Throughput is one operation per 34 cycles.
- o_done is registered and lasts exactly 1 cycle. o_stall is combinational from registered o_busy.

## Test plan

- **MULTU**
  - Stimulus: i_rs=0xFFFFFFFF, i_rt=0xFFFFFFFF.
  - Response: HI=0xFFFFFFFE, LO=0x00000001; o_done in the cycle after E33; o_busy high for cycles E0+..E33.
- **MULT**
  - Stimulus: i_rs=0xFFFFFFFD (-3), i_rt=7.
  - Response: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- **Divide, including the overflow case**
  - DIV -7/2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100/7: LO=14, HI=2.
  - DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- **Divide by zero**
  - Stimulus: DIV with i_rs=5, i_rt=0.
  - Response: o_done in the cycle after E1; LO=0xFFFFFFFF, HI=5.
- **Flush and reset mid-operation**
  - Stimulus: preload HI/LO via a MULTU 2×3 (HI=0, LO=6), then start DIVU 100/7 and assert i_flush at RUN iteration 10.
    - Response: IDLE next edge, no o_done, HI=0, LO=6.
  - Stimulus: repeat with i_rst_n low mid-RUN.
    - Response: all outputs 0 immediately.
- **Stall and back-to-back**
  - Stimulus: i_mf_req=1 or i_start=1 while busy.
  - Response: o_stall=1 until the o_done cycle, where o_stall=0; the busy-time i_start is ignored, and a start in the o_done cycle launches a second operation, with its o_done 34 cycles after the first.
